// File: rtl/accel_pkg.sv
// accel_pkg: shared types and constants for the accelerator control path.
//   ACCEL_W        default width of dimension / tile / index / count fields
//   sched_state_t  tile scheduler FSM encoding
package accel_pkg;

    localparam int ACCEL_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } sched_state_t;

endpackage

// File: rtl/tile_idx_counter.sv
// tile_idx_counter: element-offset counter for one GEMM dimension.
// The index advances by the tile size on step and wraps to 0 when the next
// tile would start at or beyond the dimension; wrap doubles as the carry into
// the next-outer dimension and as the "this is the last tile" flag.
//   clk, rst_n  clock, async active-low reset
//   clr         zero the index (job start)
//   step        advance to the next tile
//   dim, tsize  snapshotted dimension and tile size
//   idx         current element offset (registered)
//   len         min(tsize, dim - idx), the clipped extent of this tile
//   wrap        idx + tsize >= dim, evaluated at W+1 bits
module tile_idx_counter
    import accel_pkg::*;
#(
    parameter int W = ACCEL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         step,
    input  logic [W-1:0] dim,
    input  logic [W-1:0] tsize,
    output logic [W-1:0] idx,
    output logic [W-1:0] len,
    output logic         wrap
);

    logic [W:0]   sum;
    logic [W-1:0] remain;

    // One extra bit so dimensions near 2^W cannot overflow the compare.
    assign sum    = {1'b0, idx} + {1'b0, tsize};
    assign wrap   = (sum >= {1'b0, dim});
    assign remain = dim - idx;
    assign len    = (tsize < remain) ? tsize : remain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (step) begin
            idx <= wrap ? '0 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks a GEMM job over the systolic core tile by tile in
// m-outer / n-middle / k-inner order, one start/done handshake per tile.
//   start_pulse, abort_pulse  CSR one-shot controls
//   irq_en, irq_ack           interrupt enable / one-cycle clear
//   M, N, K, Tm, Tn, Tk       job config, snapshotted on an accepted start
//   tile_start, tile_abort    one-cycle commands to the core
//   tile_*_idx, tile_*_len    current tile offsets and clipped extents
//   tile_first_k/last_k       accumulator clear / drain flags
//   tile_done                 core tile-complete pulse
//   busy, done_tile_pulse, job_done_pulse, irq, tile_count   status
//   bank_sel_rd_A/B           read-bank ping-pong, flips per completed tile
// Every output is a register or a decode of registers; no input reaches an
// output combinationally.
module tile_scheduler
    import accel_pkg::*;
#(
    parameter int W = ACCEL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_pulse,
    input  logic         abort_pulse,
    input  logic         irq_en,
    input  logic         irq_ack,
    input  logic [W-1:0] M,
    input  logic [W-1:0] N,
    input  logic [W-1:0] K,
    input  logic [W-1:0] Tm,
    input  logic [W-1:0] Tn,
    input  logic [W-1:0] Tk,
    output logic         tile_start,
    output logic         tile_abort,
    output logic [W-1:0] tile_m_idx,
    output logic [W-1:0] tile_n_idx,
    output logic [W-1:0] tile_k_idx,
    output logic [W-1:0] tile_m_len,
    output logic [W-1:0] tile_n_len,
    output logic [W-1:0] tile_k_len,
    output logic         tile_first_k,
    output logic         tile_last_k,
    input  logic         tile_done,
    output logic         busy,
    output logic         done_tile_pulse,
    output logic         job_done_pulse,
    output logic         irq,
    output logic         bank_sel_rd_A,
    output logic         bank_sel_rd_B,
    output logic [W-1:0] tile_count
);

    sched_state_t state, state_nxt;

    logic [W-1:0] m_dim, n_dim, k_dim;
    logic [W-1:0] m_t, n_t, k_t;

    logic start_ok;
    logic zero_dim;
    logic tile_ack;
    logic step_k, step_n, step_m;
    logic k_wrap, n_wrap, m_wrap;
    logic job_end;

    // A start with any zero tile size would never make progress, so drop it.
    assign start_ok = (state == IDLE) && start_pulse && (|Tm) && (|Tn) && (|Tk);
    assign zero_dim = ~(|M) | ~(|N) | ~(|K);

    // Abort beats a coincident done: that tile is neither counted nor banked.
    assign tile_ack = (state == WAIT) && tile_done && !abort_pulse;

    // k steps every tile; carries ripple k -> n -> m.
    assign step_k  = (state == ADVANCE);
    assign step_n  = step_k & k_wrap;
    assign step_m  = step_n & n_wrap;
    assign job_end = k_wrap & n_wrap & m_wrap;

    tile_idx_counter #(.W(W)) u_k_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .step  (step_k),
        .dim   (k_dim),
        .tsize (k_t),
        .idx   (tile_k_idx),
        .len   (tile_k_len),
        .wrap  (k_wrap)
    );

    tile_idx_counter #(.W(W)) u_n_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .step  (step_n),
        .dim   (n_dim),
        .tsize (n_t),
        .idx   (tile_n_idx),
        .len   (tile_n_len),
        .wrap  (n_wrap)
    );

    tile_idx_counter #(.W(W)) u_m_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .step  (step_m),
        .dim   (m_dim),
        .tsize (m_t),
        .idx   (tile_m_idx),
        .len   (tile_m_len),
        .wrap  (m_wrap)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = zero_dim ? DONE : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (tile_done) state_nxt = ADVANCE;
            ADVANCE: state_nxt = job_end ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if ((state != IDLE) && abort_pulse) begin
            state_nxt = IDLE;
        end
    end

    // State-decoded outputs. The k flags are qualified with busy so that
    // the reset/idle view of the zeroed counters reads as all-zero.
    always_comb begin
        busy           = (state != IDLE);
        tile_start     = (state == ISSUE);
        job_done_pulse = (state == DONE);
        tile_first_k   = busy && (tile_k_idx == '0);
        tile_last_k    = busy && k_wrap;
    end

    // Config snapshot, status counters and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dim           <= '0;
            n_dim           <= '0;
            k_dim           <= '0;
            m_t             <= '0;
            n_t             <= '0;
            k_t             <= '0;
            tile_count      <= '0;
            tile_abort      <= 1'b0;
            done_tile_pulse <= 1'b0;
            bank_sel_rd_A   <= 1'b0;
            bank_sel_rd_B   <= 1'b0;
            irq             <= 1'b0;
        end else begin
            tile_abort      <= (state != IDLE) && abort_pulse;
            done_tile_pulse <= tile_ack;

            if (start_ok) begin
                m_dim      <= M;
                n_dim      <= N;
                k_dim      <= K;
                m_t        <= Tm;
                n_t        <= Tn;
                k_t        <= Tk;
                tile_count <= '0;
            end else if (tile_ack) begin
                tile_count    <= tile_count + W'(1);
                bank_sel_rd_A <= ~bank_sel_rd_A;
                bank_sel_rd_B <= ~bank_sel_rd_B;
            end

            // irq is raised on the edge into DONE so it is visible together
            // with job_done_pulse; a set beats a same-cycle clear.
            if ((state_nxt == DONE) && (state != DONE) && irq_en) begin
                irq <= 1'b1;
            end else if (irq_ack || start_ok) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
module tb_tile_scheduler;

    localparam int W   = 32;
    localparam int LAT = 5;

    typedef struct packed {
        logic [W-1:0] mi, ni, ki, ml, nl, kl;
        logic         f, l;
    } tile_t;

    logic         clk, rst_n;
    logic         start_pulse, abort_pulse, irq_en, irq_ack;
    logic [W-1:0] M, N, K, Tm, Tn, Tk;
    logic         tile_start, tile_abort;
    logic [W-1:0] tile_m_idx, tile_n_idx, tile_k_idx;
    logic [W-1:0] tile_m_len, tile_n_len, tile_k_len;
    logic         tile_first_k, tile_last_k, tile_done;
    logic         busy, done_tile_pulse, job_done_pulse, irq;
    logic         bank_sel_rd_A, bank_sel_rd_B;
    logic [W-1:0] tile_count;

    tile_scheduler #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_pulse(start_pulse), .abort_pulse(abort_pulse),
        .irq_en(irq_en), .irq_ack(irq_ack),
        .M(M), .N(N), .K(K), .Tm(Tm), .Tn(Tn), .Tk(Tk),
        .tile_start(tile_start), .tile_abort(tile_abort),
        .tile_m_idx(tile_m_idx), .tile_n_idx(tile_n_idx), .tile_k_idx(tile_k_idx),
        .tile_m_len(tile_m_len), .tile_n_len(tile_n_len), .tile_k_len(tile_k_len),
        .tile_first_k(tile_first_k), .tile_last_k(tile_last_k),
        .tile_done(tile_done), .busy(busy),
        .done_tile_pulse(done_tile_pulse), .job_done_pulse(job_done_pulse),
        .irq(irq), .bank_sel_rd_A(bank_sel_rd_A), .bank_sel_rd_B(bank_sel_rd_B),
        .tile_count(tile_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_chk = 0, n_fail = 0;
    tile_t exp_q[$];
    int    n_ts = 0, n_dtp = 0, n_jd = 0, n_ab = 0, n_tog = 0;
    int    abort_at = -1, done_seen = 0;
    int    s_ts, s_dtp, s_jd, s_ab;
    logic  bank_exp;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic outs_or();
        return |{tile_start, tile_abort, tile_m_idx, tile_n_idx, tile_k_idx,
                 tile_m_len, tile_n_len, tile_k_len, tile_first_k, tile_last_k,
                 busy, done_tile_pulse, job_done_pulse, irq,
                 bank_sel_rd_A, bank_sel_rd_B, tile_count};
    endfunction

    // Reference walk: push up to max_t expected tiles in m/n/k order.
    task automatic push_job(input longint md, nd, kd, tm, tn, tk, input int max_t, output int cnt);
        tile_t t;
        cnt = 0;
        for (longint mi = 0; mi < md; mi += tm)
            for (longint ni = 0; ni < nd; ni += tn)
                for (longint ki = 0; ki < kd; ki += tk)
                    if (cnt < max_t) begin
                        t.mi = 32'(mi); t.ni = 32'(ni); t.ki = 32'(ki);
                        t.ml = 32'((tm < md - mi) ? tm : md - mi);
                        t.nl = 32'((tn < nd - ni) ? tn : nd - ni);
                        t.kl = 32'((tk < kd - ki) ? tk : kd - ki);
                        t.f  = (ki == 0);
                        t.l  = (ki + tk >= kd);
                        exp_q.push_back(t);
                        cnt++;
                    end
    endtask

    task automatic snap();
        s_ts = n_ts; s_dtp = n_dtp; s_jd = n_jd; s_ab = n_ab;
    endtask

    task automatic start_job(input logic [W-1:0] m, n, k, tm, tn, tk, input logic ien);
        @(negedge clk);
        M = m; N = n; K = k; Tm = tm; Tn = tn; Tk = tk; irq_en = ien;
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_timeout"}, (i < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic job_check(input string tag, input int issued, done, jd, ab);
        bank_exp = bank_exp ^ done[0];
        chk({tag, "_issued"}, n_ts - s_ts, issued);
        chk({tag, "_dtp"}, n_dtp - s_dtp, done);
        chk({tag, "_jobdone"}, n_jd - s_jd, jd);
        chk({tag, "_abort"}, n_ab - s_ab, ab);
        chk({tag, "_count"}, tile_count, done);
        chk({tag, "_q_left"}, exp_q.size(), 0);
        chk({tag, "_bank"}, bank_sel_rd_A, bank_exp);
    endtask

    // Core model: answers tile_done LAT cycles after tile_start; optionally
    // raises abort on the same cycle as the abort_at-th done.
    int pend;
    initial begin
        tile_done = 1'b0; abort_pulse = 1'b0; pend = 0;
        forever begin
            @(posedge clk);
            #1;
            tile_done = 1'b0; abort_pulse = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        tile_done = 1'b1;
                        done_seen++;
                        if (done_seen == abort_at) abort_pulse = 1'b1;
                    end
                end
                if (tile_start) pend = LAT;
            end
        end
    end

    // Monitor: scoreboard pop on tile_start, pulse timing and counters.
    int    sd;
    logic  exp_dtp, prev_a;
    tile_t e, o;
    initial begin
        sd = -1; exp_dtp = 1'b0; prev_a = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sd = -1; exp_dtp = 1'b0; prev_a = 1'b0;
            end else begin
                if (sd >= 0) sd++;
                if (exp_dtp || done_tile_pulse) chk("dtp_lat", done_tile_pulse, exp_dtp);
                if (done_tile_pulse) n_dtp++;
                if (job_done_pulse) begin
                    n_jd++;
                    if (sd >= 0) chk("jd_lat", sd, 2);
                    chk("irq_at_jd", irq, irq_en);
                    sd = -1;
                end
                if (tile_abort) n_ab++;
                if (bank_sel_rd_A != prev_a) begin
                    n_tog++;
                    chk("bank_pair", bank_sel_rd_B, bank_sel_rd_A);
                end
                prev_a = bank_sel_rd_A;
                if (tile_start) begin
                    n_ts++;
                    if (sd >= 0) chk("issue_lat", sd, 2);
                    sd = -1;
                    if (exp_q.size() == 0) begin
                        chk("tile_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        o = '{tile_m_idx, tile_n_idx, tile_k_idx, tile_m_len, tile_n_len,
                              tile_k_len, tile_first_k, tile_last_k};
                        chk("tile", o, e);
                    end
                end
                exp_dtp = tile_done && !abort_pulse;
                if (tile_done && !abort_pulse) sd = 0;
            end
        end
    end

    int cnt;
    initial begin
        rst_n = 1'b0; start_pulse = 1'b0; irq_en = 1'b0; irq_ack = 1'b0;
        M = '0; N = '0; K = '0; Tm = '0; Tn = '0; Tk = '0;
        bank_exp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs", outs_or(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full 2x2x2 walk
        snap();
        push_job(4, 4, 4, 2, 2, 2, 100, cnt);
        start_job(4, 4, 4, 2, 2, 2, 1'b0);
        chk("walk_busy_c1", busy, 1);
        chk("walk_start_c1", tile_start, 1);
        wait_idle("walk");
        job_check("walk", 8, 8, 1, 0);
        chk("walk_irq", irq, 0);

        // Zero tile size: ignored
        snap();
        start_job(4, 4, 4, 2, 2, 0, 1'b1);
        repeat (3) @(negedge clk);
        chk("tk0_busy", busy, 0);
        chk("tk0_issued", n_ts - s_ts, 0);
        chk("tk0_count", tile_count, 8);

        // Clipped tiles, irq enabled
        snap();
        push_job(5, 2, 3, 2, 2, 2, 100, cnt);
        start_job(5, 2, 3, 2, 2, 2, 1'b1);
        wait_idle("clip");
        job_check("clip", 6, 6, 1, 0);
        chk("clip_irq", irq, 1);
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        chk("clip_irq_ack", irq, 0);

        // Abort coincident with the 3rd tile_done
        snap();
        push_job(4, 4, 4, 2, 2, 2, 3, cnt);
        abort_at = done_seen + 3;
        start_job(4, 4, 4, 2, 2, 2, 1'b1);
        wait_idle("abort");
        job_check("abort", 3, 2, 0, 1);
        chk("abort_irq", irq, 0);
        abort_at = -1;

        snap();
        push_job(2, 2, 2, 2, 2, 2, 100, cnt);
        start_job(2, 2, 2, 2, 2, 2, 1'b0);
        wait_idle("restart");
        job_check("restart", 1, 1, 1, 0);

        // Zero dimension with irq enabled
        snap();
        start_job(0, 4, 4, 2, 2, 2, 1'b1);
        chk("zd_jd_c1", job_done_pulse, 1);
        chk("zd_start_c1", tile_start, 0);
        chk("zd_irq_c1", irq, 1);
        @(negedge clk);
        chk("zd_busy_c2", busy, 0);
        repeat (3) @(negedge clk);
        chk("zd_irq_sticky", irq, 1);
        chk("zd_count", tile_count, 0);
        chk("zd_issued", n_ts - s_ts, 0);
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        chk("zd_irq_ack", irq, 0);

        // Restart and M rewrite while busy
        snap();
        push_job(4, 4, 4, 2, 2, 2, 100, cnt);
        start_job(4, 4, 4, 2, 2, 2, 1'b0);
        repeat (10) @(negedge clk);
        M = 2; start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        wait_idle("stable");
        job_check("stable", 8, 8, 1, 0);

        // Reset in WAIT
        snap();
        push_job(4, 4, 4, 2, 2, 2, 1, cnt);
        start_job(4, 4, 4, 2, 2, 2, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_in_wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", outs_or(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bank_exp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q_left", exp_q.size(), 0);
        chk("rst_no_pulse", (n_dtp - s_dtp) + (n_jd - s_jd), 0);

        snap();
        push_job(2, 2, 2, 1, 1, 1, 100, cnt);
        start_job(2, 2, 2, 1, 1, 1, 1'b0);
        wait_idle("post_rst");
        job_check("post_rst", 8, 8, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
